pipe_hazard_unit: RTL and testbench

//  Parametrised scoreboard, forwarding and load-use interlock for the in-order pipeline.
//  - Tracks the destination register of every instruction in flight after ID (EX..WB).
//  - Sits beside ID, taking the decoded rs/rt/rwd of the instruction in ID.
//  - Returns registered forward selects for EX, a combinational stall that holds IF/ID and

---
 rtl/pipe_hazard_unit.sv | 102 ++++++++++
 tb/tb_pipe_hazard_unit.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_unit.sv
// Scoreboard, forwarding-select and load-use interlock for the in-order pipeline.
// Tracks destinations of instructions in EX..WB and resolves hazards for the instruction in ID.
module pipe_hazard_unit #(
    parameter int NSTAGE   = 3,
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1,
    localparam int FWD_W   = $clog2(NSTAGE + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_rs_used,
    input  logic              id_rt_used,
    input  logic [REG_AW-1:0] id_rwd,
    input  logic              id_wen,
    input  logic              id_is_load,
    input  logic              flush,
    output logic              stall,
    output logic [FWD_W-1:0]  ex_rs_fwd,
    output logic [FWD_W-1:0]  ex_rt_fwd,
    output logic [FWD_W-1:0]  occ,
    output logic [15:0]       stall_cnt
);

    logic [NSTAGE-1:0] ent_v;
    logic [NSTAGE-1:0] ent_wen;
    logic [NSTAGE-1:0] ent_ld;
    logic [REG_AW-1:0] ent_rwd [NSTAGE];

    logic [NSTAGE-1:0] rs_hit;
    logic [NSTAGE-1:0] rt_hit;
    logic [FWD_W-1:0]  rs_sel;
    logic [FWD_W-1:0]  rt_sel;
    logic [FWD_W-1:0]  occ_c;
    logic              load_hit;
    logic              issue;

    always_comb begin
        rs_hit = '0;
        rt_hit = '0;
        for (int k = 0; k < NSTAGE; k++) begin
            rs_hit[k] = ent_v[k] & ent_wen[k] & (ent_rwd[k] == id_rs) &
                        (id_rs != '0) & id_rs_used;
            rt_hit[k] = ent_v[k] & ent_wen[k] & (ent_rwd[k] == id_rt) &
                        (id_rt != '0) & id_rt_used;
        end
    end

    // Scan oldest to youngest so the youngest producer overwrites the select last.
    always_comb begin
        rs_sel = '0;
        rt_sel = '0;
        for (int k = NSTAGE - 1; k >= 0; k--) begin
            if (rs_hit[k]) rs_sel = FWD_W'(k + 1);
            if (rt_hit[k]) rt_sel = FWD_W'(k + 1);
        end
    end

    always_comb begin
        load_hit = 1'b0;
        for (int k = 0; k < LOAD_LAT; k++) begin
            if ((rs_hit[k] | rt_hit[k]) & ent_ld[k]) load_hit = 1'b1;
        end
    end

    assign stall = id_valid & ~flush & load_hit;
    assign issue = id_valid & ~stall & ~flush;

    always_comb begin
        occ_c = '0;
        for (int k = 0; k < NSTAGE; k++) begin
            occ_c = occ_c + {{(FWD_W-1){1'b0}}, ent_v[k]};
        end
    end

    assign occ = occ_c;

    // Entries shift one stage per cycle; a stall or flush pushes a bubble into EX.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ent_v     <= '0;
            ent_wen   <= '0;
            ent_ld    <= '0;
            for (int k = 0; k < NSTAGE; k++) ent_rwd[k] <= '0;
            ex_rs_fwd <= '0;
            ex_rt_fwd <= '0;
            stall_cnt <= '0;
        end else begin
            ent_v   <= {ent_v[NSTAGE-2:0], issue};
            ent_wen <= {ent_wen[NSTAGE-2:0], issue & id_wen};
            ent_ld  <= {ent_ld[NSTAGE-2:0], issue & id_is_load};
            for (int k = NSTAGE - 1; k >= 1; k--) ent_rwd[k] <= ent_rwd[k-1];
            ent_rwd[0] <= id_rwd;
            ex_rs_fwd  <= issue ? rs_sel : '0;
            ex_rt_fwd  <= issue ? rt_sel : '0;
            if (stall && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Directed bench for pipe_hazard_unit: a vector table on the default 3/1 configuration,
// plus hand sequences on 5/3 (exact stall length, reset mid-stall) and 8/7 (counter saturation).
module tb_pipe_hazard_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_rs_used;
    logic       id_rt_used;
    logic [4:0] id_rwd;
    logic       id_wen;
    logic       id_is_load;
    logic       flush;

    logic        stall3, stall5, stall8;
    logic [1:0]  rs3, rt3, occ3;
    logic [2:0]  rs5, rt5, occ5;
    logic [3:0]  rs8, rt8, occ8;
    logic [15:0] cnt3, cnt5, cnt8;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    pipe_hazard_unit #(.NSTAGE(3), .REG_AW(5), .LOAD_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rwd(id_rwd), .id_wen(id_wen),
        .id_is_load(id_is_load), .flush(flush), .stall(stall3), .ex_rs_fwd(rs3),
        .ex_rt_fwd(rt3), .occ(occ3), .stall_cnt(cnt3));

    pipe_hazard_unit #(.NSTAGE(5), .REG_AW(5), .LOAD_LAT(3)) dut5 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rwd(id_rwd), .id_wen(id_wen),
        .id_is_load(id_is_load), .flush(flush), .stall(stall5), .ex_rs_fwd(rs5),
        .ex_rt_fwd(rt5), .occ(occ5), .stall_cnt(cnt5));

    pipe_hazard_unit #(.NSTAGE(8), .REG_AW(5), .LOAD_LAT(7)) dut8 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rwd(id_rwd), .id_wen(id_wen),
        .id_is_load(id_is_load), .flush(flush), .stall(stall8), .ex_rs_fwd(rs8),
        .ex_rt_fwd(rt8), .occ(occ8), .stall_cnt(cnt8));

    typedef struct {
        logic       valid;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       rs_used;
        logic       rt_used;
        logic [4:0] rwd;
        logic       wen;
        logic       ld;
        logic       fl;
        logic       exp_stall;
        logic [1:0] exp_rs;
        logic [1:0] exp_rt;
        logic [1:0] exp_occ;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs [18];

    task automatic applyStimulus(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                                 input logic rsu, input logic rtu, input logic [4:0] rwd,
                                 input logic wen, input logic ld, input logic fl);
        id_valid   = v;
        id_rs      = rs;
        id_rt      = rt;
        id_rs_used = rsu;
        id_rt_used = rtu;
        id_rwd     = rwd;
        id_wen     = wen;
        id_is_load = ld;
        flush      = fl;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // valid rs rt rsu rtu rwd wen ld fl | stall rs rt occ cnt (registered values after the edge)
        vecs[0]  = '{1, 1, 2, 1, 1, 3, 1, 0, 0,  0, 0, 0, 1, 0};   // add r3<-r1+r2
        vecs[1]  = '{1, 3, 1, 1, 1, 4, 1, 0, 0,  0, 1, 0, 2, 0};   // add r4<-r3+r1
        vecs[2]  = '{1, 4, 0, 1, 0, 5, 1, 1, 0,  0, 1, 0, 3, 0};   // lw r5 <- 0(r4)
        vecs[3]  = '{1, 5, 5, 1, 1, 6, 1, 0, 0,  1, 0, 0, 2, 1};   // add r6<-r5+r5 stalls
        vecs[4]  = '{1, 5, 5, 1, 1, 6, 1, 0, 0,  0, 2, 2, 2, 1};   // then forwards from entry 1
        vecs[5]  = '{1, 1, 2, 1, 1, 7, 1, 0, 0,  0, 0, 0, 2, 1};   // add r7
        vecs[6]  = '{1, 1, 2, 1, 1, 9, 1, 0, 0,  0, 0, 0, 3, 1};   // add r9
        vecs[7]  = '{1, 1, 2, 1, 1, 7, 1, 0, 0,  0, 0, 0, 3, 1};   // add r7 again
        vecs[8]  = '{1, 7, 9, 1, 1, 10, 1, 0, 0, 0, 1, 2, 3, 1};   // r7 youngest, r9 entry 1
        vecs[9]  = '{1, 1, 0, 1, 0, 0, 1, 1, 0,  0, 0, 0, 3, 1};   // lw r0
        vecs[10] = '{1, 0, 0, 1, 1, 11, 1, 0, 0, 0, 0, 0, 3, 1};   // reads r0: never matches
        vecs[11] = '{1, 11, 10, 0, 1, 12, 0, 0, 0, 0, 0, 3, 3, 1}; // rs unused, rt from WB
        vecs[12] = '{1, 12, 11, 1, 1, 13, 1, 1, 0, 0, 0, 2, 3, 1}; // rs hits wen=0 entry; lw r13
        vecs[13] = '{1, 13, 1, 1, 1, 14, 1, 0, 1, 0, 0, 0, 2, 1};  // lw-use with flush
        vecs[14] = '{0, 13, 1, 1, 1, 14, 1, 0, 0, 0, 0, 0, 1, 1};  // drain
        vecs[15] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1};   // drain
        vecs[16] = '{1, 1, 0, 1, 0, 5, 1, 1, 0,  0, 0, 0, 1, 1};   // lw r5
        vecs[17] = '{0, 5, 5, 1, 1, 6, 1, 0, 0,  0, 0, 0, 1, 1};   // invalid ID never stalls

        applyStimulus(1, 5, 5, 1, 1, 6, 1, 1, 0);
        rst_n = 1'b0;
        tick();
        tick();
        checkOutput("reset_occ", 32'(occ3), 0);
        checkOutput("reset_stall", 32'(stall3), 0);
        checkOutput("reset_cnt", 32'(cnt3), 0);
        checkOutput("reset_rs", 32'(rs3), 0);
        checkOutput("reset_rt", 32'(rt3), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            applyStimulus(vecs[i].valid, vecs[i].rs, vecs[i].rt, vecs[i].rs_used,
                          vecs[i].rt_used, vecs[i].rwd, vecs[i].wen, vecs[i].ld, vecs[i].fl);
            #1;
            checkOutput($sformatf("v%0d_stall", i), 32'(stall3), 32'(vecs[i].exp_stall));
            tick();
            checkOutput($sformatf("v%0d_rs_fwd", i), 32'(rs3), 32'(vecs[i].exp_rs));
            checkOutput($sformatf("v%0d_rt_fwd", i), 32'(rt3), 32'(vecs[i].exp_rt));
            checkOutput($sformatf("v%0d_occ", i), 32'(occ3), 32'(vecs[i].exp_occ));
            checkOutput($sformatf("v%0d_cnt", i), 32'(cnt3), 32'(vecs[i].exp_cnt));
        end

        // NSTAGE=5, LOAD_LAT=3: load matched at entry 0 stalls exactly three cycles
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        applyStimulus(1, 1, 0, 1, 0, 5, 1, 1, 0);
        tick();
        applyStimulus(1, 5, 5, 1, 1, 6, 1, 0, 0);
        for (int i = 1; i <= 3; i++) begin
            #1;
            checkOutput($sformatf("n5_stall%0d", i), 32'(stall5), 1);
            tick();
            checkOutput($sformatf("n5_cnt%0d", i), 32'(cnt5), 32'(i));
        end
        #1;
        checkOutput("n5_release", 32'(stall5), 0);
        tick();
        checkOutput("n5_rs_fwd", 32'(rs5), 4);
        checkOutput("n5_rt_fwd", 32'(rt5), 4);
        applyStimulus(1, 2, 0, 1, 0, 7, 1, 1, 0);
        tick();
        applyStimulus(1, 7, 7, 1, 1, 8, 1, 0, 0);
        #1;
        checkOutput("n5_stall_b", 32'(stall5), 1);
        tick();
        checkOutput("n5_cnt_b", 32'(cnt5), 4);
        rst_n = 1'b0;
        tick();
        checkOutput("n5_rst_occ", 32'(occ5), 0);
        checkOutput("n5_rst_cnt", 32'(cnt5), 0);
        checkOutput("n5_rst_rs", 32'(rs5), 0);
        checkOutput("n5_rst_rt", 32'(rt5), 0);
        checkOutput("n5_rst_stall", 32'(stall5), 0);
        rst_n = 1'b1;
        tick();
        checkOutput("n5_post_occ", 32'(occ5), 1);
        checkOutput("n5_post_rs", 32'(rs5), 0);
        checkOutput("n5_post_cnt", 32'(cnt5), 0);

        // NSTAGE=8, LOAD_LAT=7: a self-dependent load chain stalls 7 of every 8 cycles
        applyStimulus(1, 5, 0, 1, 0, 5, 1, 1, 0);
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 80; i++) tick();
        checkOutput("n8_cnt80", 32'(cnt8), 70);
        for (int i = 0; i < 76000; i++) tick();
        checkOutput("n8_saturate", 32'(cnt8), 32'h0000FFFF);
        tick();
        checkOutput("n8_hold", 32'(cnt8), 32'h0000FFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
